// File: rtl/ad9708_dac_driver.sv
// ad9708_dac_driver: streams samples from a small FIFO onto an AD9708-class parallel DAC.
// Divides sys_clk by CLK_DIV to make the DAC sample clock and updates the data
// bus half a DAC period before each rising (latching) edge of that clock.
// Ports:
//   sys_clk, sys_rst_n       system clock, async active-low reset
//   i_enable                 1 = stream samples, 0 = flush FIFO and drive IDLE_CODE
//   s_data/s_valid/s_ready   sample input handshake
//   o_clk_driver             DAC sample clock (DAC latches on rise)
//   o_dac_data               registered DAC data bus
//   o_level                  FIFO occupancy
//   o_underflow              one-cycle pulse when an update finds the FIFO empty
//   o_underflow_cnt          saturating count of underflows
module ad9708_dac_driver #(
    parameter int                CLK_DIV    = 4,
    parameter int                DATA_W     = 14,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] IDLE_CODE  = DATA_W'(14'h2000),
    parameter int                UFLOW_W    = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          i_enable,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          o_clk_driver,
    output logic [DATA_W-1:0]             o_dac_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_underflow,
    output logic [UFLOW_W-1:0]            o_underflow_cnt
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] RISE = CW'(CLK_DIV / 2 - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

    logic [CW-1:0]     cnt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              update, empty, push, pop;

    assign update  = cnt == LAST;
    assign empty   = o_level == '0;
    assign s_ready = i_enable && (o_level < FULL);
    assign push    = s_valid && s_ready;
    // No bypass: a word pushed on the update edge is only visible from the next one.
    assign pop     = update && i_enable && !empty;

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt             <= '0;
            o_clk_driver    <= 1'b0;
            o_dac_data      <= IDLE_CODE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            o_level         <= '0;
            o_underflow     <= 1'b0;
            o_underflow_cnt <= '0;
        end else begin
            cnt <= update ? '0 : cnt + 1'b1;
            if (cnt == RISE) o_clk_driver <= 1'b1;
            else if (update) o_clk_driver <= 1'b0;
            o_underflow <= update && i_enable && empty;
            if (update && i_enable && empty && !(&o_underflow_cnt))
                o_underflow_cnt <= o_underflow_cnt + 1'b1;
            // Data moves only on the update edge, so it is stable for half a DAC
            // period on both sides of the o_clk_driver rise.
            if (update) o_dac_data <= !i_enable ? IDLE_CODE : (empty ? o_dac_data : mem[rd_ptr]);
            if (!i_enable) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                o_level <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                o_level <= o_level + (AW + 1)'(push) - (AW + 1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_ad9708_dac_driver.sv
// tb_ad9708_dac_driver: directed self-checking bench for ad9708_dac_driver.
// dut uses default parameters; dut2 uses UFLOW_W=2 to exercise counter saturation.
module tb_ad9708_dac_driver;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        en = 1'b0, en2 = 1'b0;
    logic        s_valid = 1'b0;
    logic [13:0] s_data = '0;
    logic        s_ready, clk_drv, uf;
    logic [13:0] dac;
    logic [2:0]  level;
    logic [15:0] ufcnt;
    logic        s_ready2, clk_drv2, uf2;
    logic [13:0] dac2;
    logic [2:0]  level2;
    logic [1:0]  ufcnt2;
    int          checks = 0, errors = 0, ph = 0;
    int          pat_cnt [5] = '{1, 2, 3, 3, 3};

    ad9708_dac_driver dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_enable(en),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .o_clk_driver(clk_drv), .o_dac_data(dac), .o_level(level),
        .o_underflow(uf), .o_underflow_cnt(ufcnt)
    );

    ad9708_dac_driver #(.UFLOW_W(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_enable(en2),
        .s_data(14'h0), .s_valid(1'b0), .s_ready(s_ready2),
        .o_clk_driver(clk_drv2), .o_dac_data(dac2), .o_level(level2),
        .o_underflow(uf2), .o_underflow_cnt(ufcnt2)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        ph = (ph + 1) % 4;
    endtask

    task automatic next_update();
        tick();
        while (ph != 0) tick();
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_dac_held", 32'(dac), 32'h2000);
        sys_rst_n = 1'b1;
        ph = 0;
        chk("rst_clk", 32'(clk_drv), 0);
        chk("rst_dac", 32'(dac), 32'h2000);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_uf", 32'(uf), 0);
        chk("rst_ufcnt", 32'(ufcnt), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("clk_pattern", 32'(clk_drv), (ph == 2 || ph == 3) ? 1 : 0);
        end
        en = 1'b1;
        s_valid = 1'b1;
        s_data = 14'h1;
        tick();
        s_data = 14'h2;
        tick();
        s_data = 14'h3;
        tick();
        s_valid = 1'b0;
        chk("t2_level3", 32'(level), 3);
        chk("t2_dac_idle", 32'(dac), 32'h2000);
        tick();
        chk("t2_dac1", 32'(dac), 1);
        chk("t2_level2", 32'(level), 2);
        tick();
        tick();
        chk("t2_rise_clk", 32'(clk_drv), 1);
        chk("t2_rise_dac", 32'(dac), 1);
        next_update();
        chk("t2_dac2", 32'(dac), 2);
        next_update();
        chk("t2_dac3", 32'(dac), 3);
        chk("t2_level0", 32'(level), 0);
        chk("t2_no_uf", 32'(uf), 0);
        next_update();
        chk("t2_hold", 32'(dac), 3);
        chk("t2_uf", 32'(uf), 1);
        chk("t2_ufcnt", 32'(ufcnt), 1);
        tick();
        chk("t2_uf_pulse_end", 32'(uf), 0);
        while (ph != 3) tick();
        chk("t3_ready", 32'(s_ready), 1);
        s_valid = 1'b1;
        s_data = 14'h10;
        tick();
        chk("t3_hold", 32'(dac), 3);
        chk("t3_uf", 32'(uf), 1);
        chk("t3_ufcnt", 32'(ufcnt), 2);
        chk("t3_level1", 32'(level), 1);
        s_data = 14'h11;
        tick();
        s_data = 14'h12;
        tick();
        s_data = 14'h13;
        tick();
        chk("t3_full_level", 32'(level), 4);
        chk("t3_full_ready", 32'(s_ready), 0);
        s_data = 14'h14;
        tick();
        chk("t3_pop_dac", 32'(dac), 32'h10);
        chk("t3_pop_level", 32'(level), 3);
        chk("t3_pop_ready", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        chk("t3_fifth_level", 32'(level), 4);
        for (int w = 'h11; w <= 'h14; w++) begin
            next_update();
            chk("t3_order", 32'(dac), 32'(w));
        end
        chk("t3_drained", 32'(level), 0);
        chk("t3_no_uf", 32'(uf), 0);
        s_valid = 1'b1;
        s_data = 14'h20;
        tick();
        s_data = 14'h21;
        tick();
        s_data = 14'h22;
        tick();
        s_valid = 1'b0;
        chk("t4_level3", 32'(level), 3);
        en = 1'b0;
        #1;
        chk("t4_ready_off", 32'(s_ready), 0);
        tick();
        chk("t4_dac_idle", 32'(dac), 32'h2000);
        chk("t4_flush", 32'(level), 0);
        chk("t4_uf", 32'(uf), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t4_no_uf_off", 32'(uf), 0);
        end
        chk("t4_ufcnt", 32'(ufcnt), 2);
        chk("t4_dac_still_idle", 32'(dac), 32'h2000);
        en = 1'b1;
        s_valid = 1'b1;
        s_data = 14'h30;
        tick();
        s_data = 14'h31;
        tick();
        s_valid = 1'b0;
        next_update();
        chk("t5_dac30", 32'(dac), 32'h30);
        chk("t5_level1", 32'(level), 1);
        tick();
        tick();
        chk("t5_clk_high", 32'(clk_drv), 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t5_async_clk", 32'(clk_drv), 0);
        chk("t5_async_dac", 32'(dac), 32'h2000);
        chk("t5_async_level", 32'(level), 0);
        chk("t5_async_ufcnt", 32'(ufcnt), 0);
        chk("t5_async_uf", 32'(uf), 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        ph = 0;
        s_valid = 1'b1;
        s_data = 14'h40;
        tick();
        s_valid = 1'b0;
        chk("t5_restart_level", 32'(level), 1);
        next_update();
        chk("t5_restart_dac", 32'(dac), 32'h40);
        chk("t5_restart_level0", 32'(level), 0);
        chk("t5_restart_uf", 32'(uf), 0);
        chk("t5_restart_ufcnt", 32'(ufcnt), 0);
        en2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_uf_low", 32'(uf2), 0);
            next_update();
            chk("t6_uf_pulse", 32'(uf2), 1);
            chk("t6_ufcnt_sat", 32'(ufcnt2), 32'(pat_cnt[i]));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
